// File: rtl/phase_unwrap.sv
// phase_unwrap: wrapped-phase difference, continuous unwrap and block-averaged frequency
module phase_unwrap #(
  parameter int ANGLE_W  = 19,
  parameter int FRAC     = 10,
  parameter int PI_Q     = 3217,
  parameter int TWO_PI_Q = 6434,
  parameter int ACC_W    = 24,
  parameter int LOG2_AVG = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic signed [ANGLE_W-1:0] in_angle,
  output logic                      delta_valid,
  output logic signed [ANGLE_W-1:0] delta,
  output logic signed [ACC_W-1:0]   unwrap,
  output logic                      freq_valid,
  output logic signed [ANGLE_W-1:0] freq
);
  localparam int SW = ANGLE_W + LOG2_AVG;
  localparam logic signed [ANGLE_W-1:0] PI_A = ANGLE_W'(PI_Q);
  localparam logic signed [ANGLE_W:0]   PI_W = (ANGLE_W+1)'(PI_Q);
  localparam logic signed [ANGLE_W:0]   TPI_W = (ANGLE_W+1)'(TWO_PI_Q);
  if (TWO_PI_Q != 2 * PI_Q || PI_Q >= (4 << FRAC)) begin : g_bad_params
    $error("phase_unwrap: inconsistent angle parameters");
  end
  typedef enum logic {EMPTY, RUN} state_t;
  state_t                      state;
  logic signed [ANGLE_W-1:0]   prev, sat, d_n;
  logic signed [ANGLE_W:0]     raw_n, s1_raw;
  logic                        s1_valid, s1_first, blk_done;
  logic [LOG2_AVG-1:0]         count;
  logic signed [SW-1:0]        sum, sum_n;
  logic signed [ACC_W-1:0]     d_acc, first_acc;
  always_comb begin
    sat = in_angle > PI_A ? PI_A : in_angle < -PI_A ? -PI_A : in_angle;
    raw_n = {sat[ANGLE_W-1], sat} - {prev[ANGLE_W-1], prev};
    d_n = s1_first ? '0 :
          s1_raw > PI_W  ? ANGLE_W'(s1_raw - TPI_W) :
          s1_raw < -PI_W ? ANGLE_W'(s1_raw + TPI_W) : ANGLE_W'(s1_raw);
    d_acc = {{(ACC_W-ANGLE_W){d_n[ANGLE_W-1]}}, d_n};
    first_acc = {{(ACC_W-ANGLE_W){s1_raw[ANGLE_W-1]}}, s1_raw[ANGLE_W-1:0]};
    sum_n = (blk_done ? '0 : sum) + {{LOG2_AVG{d_n[ANGLE_W-1]}}, d_n};
  end
  // The first sample after EMPTY carries its own captured angle in s1_raw so it can seed unwrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset || clear) begin
      state       <= EMPTY;
      prev        <= '0;
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_raw      <= '0;
      delta_valid <= 1'b0;
      delta       <= '0;
      unwrap      <= '0;
      freq_valid  <= 1'b0;
      freq        <= '0;
      blk_done    <= 1'b0;
      count       <= '0;
      sum         <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_raw   <= state == EMPTY ? {sat[ANGLE_W-1], sat} : raw_n;
        s1_first <= state == EMPTY;
        prev     <= sat;
        state    <= RUN;
      end
      delta_valid <= s1_valid;
      if (s1_valid) begin
        delta  <= d_n;
        unwrap <= s1_first ? first_acc : unwrap + d_acc;
      end
      freq_valid <= blk_done;
      if (blk_done) freq <= sum[SW-1:LOG2_AVG];
      blk_done <= s1_valid && !s1_first && &count;
      if (s1_valid && !s1_first) begin
        sum   <= sum_n;
        count <= count + 1'b1;
      end else if (blk_done) sum <= '0;
    end
  end
endmodule

// File: tb/tb_phase_unwrap.sv
// tb_phase_unwrap: directed and random stimulus against a scoreboard model of phase_unwrap
module tb_phase_unwrap;
  localparam int PI = 3217, TPI = 6434;
  logic clock = 1'b0, reset = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic signed [18:0] in_angle = '0;
  logic delta_valid, freq_valid;
  logic signed [18:0] delta, freq;
  logic signed [23:0] unwrap;
  phase_unwrap dut (.clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_angle(in_angle), .delta_valid(delta_valid), .delta(delta), .unwrap(unwrap),
    .freq_valid(freq_valid), .freq(freq));
  initial forever #5 clock = ~clock;
  typedef struct {int due; int d; int u;} dexp_t;
  typedef struct {int due; int f;} fexp_t;
  dexp_t dq[$];
  fexp_t fq[$];
  int checks = 0, errors = 0, cyc = 0;
  bit m_run;
  int m_prev, m_u, m_sum, m_cnt;
  logic e_dv, e_fv;
  int e_d, e_f;
  logic signed [23:0] e_u;
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d observed %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    dq.delete(); fq.delete();
    m_run = 0; m_prev = 0; m_u = 0; m_sum = 0; m_cnt = 0;
    e_dv = 0; e_fv = 0; e_d = 0; e_f = 0; e_u = '0;
  endtask
  task automatic model_sample(input int a);
    int s, raw, d;
    s = a > PI ? PI : a < -PI ? -PI : a;
    if (!m_run) begin
      d = 0; m_u = s; m_run = 1;
    end else begin
      raw = s - m_prev;
      d = raw > PI ? raw - TPI : raw < -PI ? raw + TPI : raw;
      m_u += d; m_sum += d; m_cnt++;
      if (m_cnt == 8) begin
        fq.push_back('{cyc + 2, m_sum >>> 3});
        m_sum = 0; m_cnt = 0;
      end
    end
    m_prev = s;
    dq.push_back('{cyc + 1, d, m_u});
  endtask
  task automatic check_all();
    chk("delta_valid", {31'd0, delta_valid}, {31'd0, e_dv});
    chk("delta", delta, e_d);
    chk("unwrap", unwrap, e_u);
    chk("freq_valid", {31'd0, freq_valid}, {31'd0, e_fv});
    chk("freq", freq, e_f);
  endtask
  task automatic step(input logic v, input int a, input logic c);
    in_valid = v; in_angle = 19'(a); clear = c;
    @(posedge clock);
    cyc++;
    if (c) model_reset();
    else if (v) model_sample(a);
    e_dv = 0; e_fv = 0;
    if (dq.size() > 0 && dq[0].due == cyc) begin
      e_dv = 1; e_d = dq[0].d; e_u = 24'(dq[0].u);
      void'(dq.pop_front());
    end
    if (fq.size() > 0 && fq[0].due == cyc) begin
      e_fv = 1; e_f = fq[0].f;
      void'(fq.pop_front());
    end
    #1 check_all();
  endtask
  task automatic send(input int a);
    step(1, a, 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1 check_all();
    @(negedge clock) reset = 1'b1;
    send(100); send(1200); send(-900); send(50);
    in_valid = 0;
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clock) reset = 1'b1;
    send(500); idle(3);
    step(0, 0, 1);
    for (int i = 0; i <= 8; i++) send(i * 100);
    idle(4);
    step(0, 0, 1); send(3000); send(-3000); idle(2);
    step(0, 0, 1); send(-3000); send(3000); idle(2);
    step(0, 0, 1); send(0); send(3217); idle(2);
    step(0, 0, 1); send(-1609); send(1609); idle(2);
    step(0, 0, 1); send(4000); send(0); send(-4000); idle(2);
    step(0, 0, 1);
    for (int i = 0; i <= 8; i++) send(i < 4 ? -i : -4);
    idle(3);
    step(0, 0, 1);
    for (int i = 0; i <= 8; i++) send(i < 4 ? i : 4);
    idle(3);
    step(0, 0, 1);
    send(100); send(200); send(300); send(400); send(500); step(1, 600, 1);
    idle(3);
    send(700);
    for (int i = 1; i <= 8; i++) send(700 + i * 37);
    idle(4);
    step(0, 0, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, int'($urandom_range(9000)) - 4500, $urandom_range(49) == 0);
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
